// File: rtl/compress_pkg.sv
// Shared definitions for the compression / decompression pair.
// Code-type encoding, widths and the push rule live here so that the
// compressor's control generator and this decoder keep their dictionaries
// in lock-step.
package compress_pkg;

  localparam int unsigned WORD       = 32;
  localparam int unsigned WIDTH      = 2 * WORD;
  localparam int unsigned DICT_ENTRY = 16;
  localparam int unsigned INDEX_W    = 4;

  typedef enum logic [2:0] {
    ZZZZ = 3'd0,
    ZZZX = 3'd1,
    MMMM = 3'd2,
    MMXX = 3'd3,
    MMMX = 3'd4,
    XXXX = 3'd5
  } code_t;

  // A word enters the dictionary only when it carries literal bits.
  function automatic logic push_flag(input logic [2:0] code);
    case (code)
      ZZZX, MMXX, MMMX, XXXX: push_flag = 1'b1;
      default:                push_flag = 1'b0;
    endcase
  endfunction

  // Codes 6 and 7 are not defined.
  function automatic logic legal_code(input logic [2:0] code);
    legal_code = (code < 3'd6);
  endfunction

endpackage

// File: rtl/decompression_stage_if.sv
// Token-in / word-out bus of the decompression stage.
// Upstream side: i_valid/o_ready plus two parsed tokens (type, index, literal).
// Downstream side: o_valid/i_ready plus the rebuilt 64-bit word.
// Status: flat dictionary contents and the sticky error flag.
// slave = decompression stage, master = unpacker/sink/bench side.
interface decompression_stage_if;
  import compress_pkg::*;

  logic                        i_valid;
  logic                        o_ready;
  logic [2:0]                  i_type1;
  logic [INDEX_W-1:0]          i_index1;
  logic [WORD-1:0]             i_literal1;
  logic [2:0]                  i_type2;
  logic [INDEX_W-1:0]          i_index2;
  logic [WORD-1:0]             i_literal2;
  logic                        o_valid;
  logic                        i_ready;
  logic [WIDTH-1:0]            o_word;
  logic [DICT_ENTRY*WORD-1:0]  o_dictionary_data;
  logic                        o_error;

  modport slave (
    input  i_valid, i_type1, i_index1, i_literal1, i_type2, i_index2, i_literal2, i_ready,
    output o_ready, o_valid, o_word, o_dictionary_data, o_error
  );

  modport master (
    output i_valid, i_type1, i_index1, i_literal1, i_type2, i_index2, i_literal2, i_ready,
    input  o_ready, o_valid, o_word, o_dictionary_data, o_error
  );
endinterface

// File: rtl/decomp_dict.sv
// 16-entry shift-FIFO dictionary. Entry 0 is newest, entry 15 oldest.
// Ports: i_clk, i_reset (async active-low), i_clear (sync zero),
//        i_wr1/i_word1 and i_wr2/i_word2 (one or two pushes per cycle,
//        word 2 ends up newest), o_data (entry k at bits [32k+31:32k]).
module decomp_dict
  import compress_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_clear,
  input  logic                       i_wr1,
  input  logic [WORD-1:0]            i_word1,
  input  logic                       i_wr2,
  input  logic [WORD-1:0]            i_word2,
  output logic [DICT_ENTRY*WORD-1:0] o_data
);

  logic [WORD-1:0] entries_q [DICT_ENTRY];
  logic [WORD-1:0] entries_d [DICT_ENTRY];
  logic [WORD-1:0] base      [DICT_ENTRY];

  always_comb begin
    // Clear happens first; same-cycle pushes land on the empty dictionary.
    for (int k = 0; k < DICT_ENTRY; k++) begin
      base[k] = i_clear ? '0 : entries_q[k];
    end
    entries_d = base;
    if (i_wr1 && i_wr2) begin
      entries_d[0] = i_word2;
      entries_d[1] = i_word1;
      for (int k = 2; k < DICT_ENTRY; k++) entries_d[k] = base[k-2];
    end else if (i_wr1 || i_wr2) begin
      entries_d[0] = i_wr1 ? i_word1 : i_word2;
      for (int k = 1; k < DICT_ENTRY; k++) entries_d[k] = base[k-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < DICT_ENTRY; k++) entries_q[k] <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

  always_comb begin
    o_data = '0;
    for (int k = 0; k < DICT_ENTRY; k++) o_data[WORD*k +: WORD] = entries_q[k];
  end

endmodule

// File: rtl/decompression_stage.sv
// Decompression stage: rebuilds one 64-bit word per accepted token pair.
// Ports: i_clk, i_reset (async active-low), i_clear (sync dictionary/error
//        clear), bus (token input handshake, word output handshake,
//        flat dictionary view and sticky error flag).
// Word 1 decodes against the current dictionary; word 2 sees word 1's push.
module decompression_stage
  import compress_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  decompression_stage_if.slave  bus
);

  logic [DICT_ENTRY*WORD-1:0] dict_data;
  logic [WORD-1:0]            view1 [DICT_ENTRY];
  logic [WORD-1:0]            d1;
  logic [WORD-1:0]            d2;
  logic [WORD-1:0]            word1;
  logic [WORD-1:0]            word2;
  logic                       push1;
  logic                       push2;
  logic                       illegal;
  logic                       accept;
  logic                       valid_q;
  logic [WIDTH-1:0]           word_q;
  logic                       error_q;
  logic                       error_d;

  function automatic logic [WORD-1:0] decode(input logic [2:0]      code,
                                             input logic [WORD-1:0] d,
                                             input logic [WORD-1:0] lit);
    case (code)
      ZZZZ:    decode = '0;
      ZZZX:    decode = {24'b0, lit[7:0]};
      MMMM:    decode = d;
      MMXX:    decode = {d[31:16], lit[15:0]};
      MMMX:    decode = {d[31:8], lit[7:0]};
      XXXX:    decode = lit;
      default: decode = '0;
    endcase
  endfunction

  assign accept      = bus.i_valid && bus.o_ready;
  assign bus.o_ready = !valid_q || bus.i_ready;

  // A same-cycle clear means the pair decodes against an all-zero dictionary.
  always_comb begin
    for (int k = 0; k < DICT_ENTRY; k++) begin
      view1[k] = i_clear ? '0 : dict_data[WORD*k +: WORD];
    end
  end

  assign push1 = push_flag(bus.i_type1);
  assign push2 = push_flag(bus.i_type2);
  assign d1    = view1[bus.i_index1];
  assign word1 = decode(bus.i_type1, d1, bus.i_literal1);

  // Forwarded view for word 2: if word 1 pushed, everything moved down one.
  always_comb begin
    d2 = view1[bus.i_index2];
    if (push1) begin
      d2 = (bus.i_index2 == '0) ? word1 : view1[bus.i_index2 - 4'd1];
    end
  end

  assign word2   = decode(bus.i_type2, d2, bus.i_literal2);
  assign illegal = !legal_code(bus.i_type1) || !legal_code(bus.i_type2);

  decomp_dict u_dict (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_clear),
    .i_wr1   (accept && push1),
    .i_word1 (word1),
    .i_wr2   (accept && push2),
    .i_word2 (word2),
    .o_data  (dict_data)
  );

  // Error raised by a pair accepted together with a clear survives the clear.
  assign error_d = (i_clear ? 1'b0 : error_q) | (accept & illegal);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
      if (accept) begin
        valid_q <= 1'b1;
        word_q  <= {word2, word1};
      end else if (bus.i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_valid           = valid_q;
  assign bus.o_word            = word_q;
  assign bus.o_error           = error_q;
  assign bus.o_dictionary_data = dict_data;

endmodule

// File: tb/tb_decompression_stage.sv
// Scoreboard bench for decompression_stage: the driver queues the expected
// word on every accept, a negedge monitor pops and compares on each transfer.
module tb_decompression_stage;
  import compress_pkg::*;

  logic clk;
  logic rst_n;
  logic clear;
  int   n_cmp;
  int   n_bad;
  logic [63:0] exp_q [$];

  decompression_stage_if bus ();

  decompression_stage dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .i_clear (clear),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int k);
    ent = bus.o_dictionary_data[32*k +: 32];
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a pair until accepted (bounded); queues its expected word.
  task automatic send(input logic [2:0] t1, input logic [3:0] x1, input logic [31:0] l1,
                      input logic [2:0] t2, input logic [3:0] x2, input logic [31:0] l2,
                      input logic [63:0] exp);
    int n;
    bit done;
    n = 0;
    done = 0;
    bus.i_type1 = t1; bus.i_index1 = x1; bus.i_literal1 = l1;
    bus.i_type2 = t2; bus.i_index2 = x2; bus.i_literal2 = l2;
    bus.i_valid = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk);
      if (bus.o_ready) begin
        exp_q.push_back(exp);
        @(posedge clk);
        done = 1;
      end
      n++;
    end
    #1 bus.i_valid = 1'b0;
    if (!done) chk("accept_timeout", 512'd0, 512'd1);
  endtask

  // Monitor: one compare per completed output transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", {448'd0, bus.o_word}, 512'd0);
        else chk("o_word", {448'd0, bus.o_word}, {448'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_type1 = 3'd0; bus.i_index1 = 4'd0; bus.i_literal1 = 32'd0;
    bus.i_type2 = 3'd0; bus.i_index2 = 4'd0; bus.i_literal2 = 32'd0;
    #23 rst_n = 1'b1;
    idle(1);

    chk("reset_o_valid", {511'd0, bus.o_valid}, 512'd0);
    chk("reset_o_ready", {511'd0, bus.o_ready}, 512'd1);
    chk("reset_o_error", {511'd0, bus.o_error}, 512'd0);
    chk("reset_o_word", {448'd0, bus.o_word}, 512'd0);
    chk("reset_dict", bus.o_dictionary_data, 512'd0);

    // Two literals.
    send(XXXX, 4'd0, 32'hDEADBEEF, XXXX, 4'd0, 32'h12345678, 64'h12345678_DEADBEEF);
    chk("p1_entry0", {480'd0, ent(0)}, {480'd0, 32'h12345678});
    chk("p1_entry1", {480'd0, ent(1)}, {480'd0, 32'hDEADBEEF});

    // Full match + partial match; only word 2 pushes.
    send(MMMM, 4'd1, 32'd0, MMXX, 4'd0, 32'h0000AAAA, 64'h1234AAAA_DEADBEEF);
    chk("p2_entry0", {480'd0, ent(0)}, {480'd0, 32'h1234AAAA});
    chk("p2_entry1", {480'd0, ent(1)}, {480'd0, 32'h12345678});
    chk("p2_entry2", {480'd0, ent(2)}, {480'd0, 32'hDEADBEEF});

    // Word 2 matches word 1 through the forwarded view.
    send(XXXX, 4'd0, 32'hCAFEF00D, MMMX, 4'd0, 32'h00000077, 64'hCAFEF077_CAFEF00D);
    chk("p3_entry0", {480'd0, ent(0)}, {480'd0, 32'hCAFEF077});
    chk("p3_entry1", {480'd0, ent(1)}, {480'd0, 32'hCAFEF00D});

    // 18 pushes overflow the 16-entry FIFO.
    for (int j = 0; j < 9; j++) begin
      send(XXXX, 4'd0, 32'h1000_0000 + 32'(2*j), XXXX, 4'd0, 32'h1000_0000 + 32'(2*j+1),
           {32'h1000_0000 + 32'(2*j+1), 32'h1000_0000 + 32'(2*j)});
    end
    chk("ovf_entry15", {480'd0, ent(15)}, {480'd0, 32'h10000002});
    chk("ovf_entry0", {480'd0, ent(0)}, {480'd0, 32'h10000011});

    // Zero codes; ZZZZ must not push.
    send(ZZZX, 4'd0, 32'hFFFFFF5A, ZZZZ, 4'd0, 32'hFFFFFFFF, 64'h00000000_0000005A);
    chk("zz_entry0", {480'd0, ent(0)}, {480'd0, 32'h0000005A});
    chk("zz_entry1", {480'd0, ent(1)}, {480'd0, 32'h10000011});
    idle(2);

    // Back-pressure.
    bus.i_ready = 1'b0;
    send(XXXX, 4'd0, 32'h11111111, XXXX, 4'd0, 32'h22222222, 64'h22222222_11111111);
    bus.i_type1 = XXXX; bus.i_index1 = 4'd0; bus.i_literal1 = 32'h33333333;
    bus.i_type2 = MMMM; bus.i_index2 = 4'd0; bus.i_literal2 = 32'd0;
    bus.i_valid = 1'b1;
    exp_q.push_back(64'h33333333_33333333);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_o_ready", {511'd0, bus.o_ready}, 512'd0);
      chk("bp_o_word", {448'd0, bus.o_word}, {448'd0, 64'h22222222_11111111});
      chk("bp_entry0", {480'd0, ent(0)}, {480'd0, 32'h22222222});
    end
    @(posedge clk);
    #1 bus.i_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    chk("bp_entry0_after", {480'd0, ent(0)}, {480'd0, 32'h33333333});
    chk("bp_entry1_after", {480'd0, ent(1)}, {480'd0, 32'h22222222});

    // Illegal code in word 1.
    send(3'd7, 4'd0, 32'hFFFFFFFF, XXXX, 4'd0, 32'h44444444, 64'h44444444_00000000);
    chk("err_set", {511'd0, bus.o_error}, 512'd1);
    chk("err_entry0", {480'd0, ent(0)}, {480'd0, 32'h44444444});
    chk("err_entry1", {480'd0, ent(1)}, {480'd0, 32'h33333333});
    idle(2);
    chk("err_sticky", {511'd0, bus.o_error}, 512'd1);

    // Standalone clear.
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    chk("clr_error", {511'd0, bus.o_error}, 512'd0);
    chk("clr_dict", bus.o_dictionary_data, 512'd0);

    // Repopulate, then clear together with an accept.
    send(XXXX, 4'd0, 32'h66666666, XXXX, 4'd0, 32'h77777777, 64'h77777777_66666666);
    clear = 1'b1;
    send(XXXX, 4'd0, 32'h55555555, MMMM, 4'd1, 32'd0, 64'h00000000_55555555);
    clear = 1'b0;
    chk("clracc_entry0", {480'd0, ent(0)}, {480'd0, 32'h55555555});
    chk("clracc_entry1", {480'd0, ent(1)}, {480'd0, 32'h00000000});
    idle(2);

    // Reset while a word is pending.
    bus.i_ready = 1'b0;
    send(XXXX, 4'd0, 32'h88888888, XXXX, 4'd0, 32'h99999999, 64'h99999999_88888888);
    chk("pre_rst_valid", {511'd0, bus.o_valid}, 512'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_o_valid", {511'd0, bus.o_valid}, 512'd0);
    chk("rst_o_word", {448'd0, bus.o_word}, 512'd0);
    chk("rst_dict", bus.o_dictionary_data, 512'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    idle(1);
    chk("rst_o_ready", {511'd0, bus.o_ready}, 512'd1);

    idle(3);
    chk("queue_drained", 512'(exp_q.size()), 512'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
